// File: rtl/pp_pkg.sv
// pp_pkg: definitions shared by the rdy/ack pipeline blocks.
//
// Handshake semantics used by every block that imports this package:
// a producer raises rdy and keeps rdy and its data stable until the
// consumer answers with ack in the same cycle. ack means nothing while
// rdy is low, and a transfer happens on each rising edge where rdy && ack.
//
// Contents:
//   PP_CNT_W(ratio) - width of a counter that must hold 0..ratio inclusive.
package pp_pkg;

  function automatic int PP_CNT_W(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/pp_out_slice.sv
// pp_out_slice: rdy/ack holding register for one pipeline word.
//
// Ports:
//   clk      in      clock, rising edge
//   rst      in      synchronous reset, active-high (drops any held word)
//   load     in      capture load_dat and present it; caller only loads when free=1
//   load_dat in  W   word to capture
//   ack      in      downstream accepts the held word (ignored while rdy=0)
//   free     out     register can take a new word this cycle (!rdy || ack)
//   rdy      out     held word valid (registered)
//   dat      out W   held word (registered; keeps its last value after retire)
//
// A load in the same cycle as ack replaces the retiring word directly,
// so rdy stays high with no bubble.
module pp_out_slice #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         ack,
  output logic         free,
  output logic         rdy,
  output logic [W-1:0] dat
);

  assign free = !rdy || ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy <= 1'b0;
      dat <= '0;
    end else if (load) begin
      rdy <= 1'b1;
      dat <= load_dat;
    end else if (ack) begin
      // Retire: data is left as-is, only the valid flag drops.
      rdy <= 1'b0;
    end
  end

endmodule

// File: rtl/pp_beat_packer.sv
// pp_beat_packer: stream width-up converter on the rdy/ack protocol.
// Packs RATIO accepted IN_BW-bit beats into one IN_BW*RATIO-bit word.
//
// Parameters:
//   IN_BW     input beat width in bits (>=1)
//   RATIO     beats per output word (>=2)
//   MSB_FIRST 1: first beat ends in the top slice of o_dat
//             0: first beat ends in o_dat[IN_BW-1:0]
//
// Ports:
//   clk    in                 clock, rising edge
//   rst    in                 synchronous reset, active-high
//   i_rdy  in                 upstream beat valid
//   i_dat  in  IN_BW          upstream beat (don't-care while i_rdy=0)
//   i_ack  out                beat accepted this cycle (combinational)
//   o_rdy  out                packed word valid (registered)
//   o_dat  out IN_BW*RATIO    packed word (registered)
//   o_ack  in                 downstream accepts the word (only honoured when o_rdy=1)
//
// The accumulator holds a complete word (cnt==RATIO) until the output
// register is free. In the cycle the word moves out, a new beat may be
// accepted into a cleared accumulator, so streaming runs at one beat per
// cycle with no bubble between words.
module pp_beat_packer
  import pp_pkg::*;
#(
  parameter int IN_BW     = 8,
  parameter int RATIO     = 32,
  parameter int MSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rdy,
  input  logic [IN_BW-1:0]       i_dat,
  output logic                   i_ack,
  output logic                   o_rdy,
  output logic [IN_BW*RATIO-1:0] o_dat,
  input  logic                   o_ack
);

  localparam int            W        = IN_BW * RATIO;
  localparam int            CW       = PP_CNT_W(RATIO);
  localparam logic [CW-1:0] CNT_FULL = CW'(RATIO);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [W-1:0]  acc;
  logic [W-1:0]  acc_base;
  logic [W-1:0]  acc_shift;
  logic [CW-1:0] cnt;
  logic          full;
  logic          out_free;
  logic          xfer;

  always_comb begin
    full     = (cnt == CNT_FULL);
    xfer     = full && out_free;
    i_ack    = i_rdy && (!full || xfer);
    // On a transfer the finished word leaves this cycle, so an incoming
    // beat starts from an empty accumulator.
    acc_base = xfer ? '0 : acc;
  end

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign acc_shift = {acc_base[W-IN_BW-1:0], i_dat};
    end else begin : g_lsb_first
      assign acc_shift = {i_dat, acc_base[W-1:IN_BW]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      if (i_ack) begin
        acc <= acc_shift;
      end else if (xfer) begin
        acc <= '0;
      end

      case ({xfer, i_ack})
        2'b11:   cnt <= CNT_ONE;
        2'b10:   cnt <= '0;
        2'b01:   cnt <= cnt + CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  pp_out_slice #(
    .W (W)
  ) u_out_slice (
    .clk      (clk),
    .rst      (rst),
    .load     (xfer),
    .load_dat (acc),
    .ack      (o_ack),
    .free     (out_free),
    .rdy      (o_rdy),
    .dat      (o_dat)
  );

endmodule

// File: doc/pp_beat_packer.md
# pp_beat_packer

Stream width-up converter on the rdy/ack pipeline protocol. Accepts `IN_BW`-bit beats from an upstream source and emits one `IN_BW*RATIO`-bit word per `RATIO` accepted beats; e.g. 8-bit bytes from the byte source are packed into 256-bit operands for the RSA core. Both ports obey the pipeline protocol:
- Once a port raises `rdy`, `rdy` and its data stay stable until `ack`.
- `ack` is only meaningful while `rdy` is high.

The block sits directly upstream of the consuming core. It is driven by `PPRandomSrc`/`PPFileInitiator` in benches, with `PPRandomDst`/`PPFileMonitor` on its output.

## Interface
Parameters:
- `IN_BW`, default 8: input beat width (bits), ≥1.
- `RATIO`, default 32: beats per output word, ≥2.
- `MSB_FIRST`, default 1: 1 = first beat lands in the top slice of `o_dat`; 0 = first beat lands in bits `[IN_BW-1:0]`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `i_rdy` in 1: upstream beat valid.
- `i_dat` in `IN_BW`: upstream beat. Don't-care (may be X) while `i_rdy`=0.
- `i_ack` out 1: beat accepted this cycle. Combinational.
- `o_rdy` out 1: packed word valid. Registered.
- `o_dat` out `IN_BW*RATIO`: packed word. Registered.
- `o_ack` in 1: downstream accepts the word. Only honoured when `o_rdy`=1.

## Operation
- State consists of three parts:
  - accumulator `acc` (`IN_BW*RATIO` bits);
  - beat counter `cnt`, range 0..`RATIO`, width `$clog2(RATIO+1)`;
  - output holding register `o_dat`/`o_rdy`.
- Define:
  - `full` = (`cnt`==`RATIO`)
  - `out_free` = !`o_rdy` || `o_ack`
  - `xfer` = `full` && `out_free`
  - `i_ack` = `i_rdy` && (!`full` || `xfer`)
- Accept (`i_ack`=1):
  - `MSB_FIRST`=1: `acc` shifts left by `IN_BW`, and `i_dat` enters the LSBs.
  - `MSB_FIRST`=0: `acc` shifts right by `IN_BW`, and `i_dat` enters the MSBs.
- Transfer (`xfer`=1):
  - `o_dat` ← `acc`, `o_rdy` ← 1.
- Counter update:
  - `xfer` && `i_ack`: `cnt` ← 1, and the new beat is written into a cleared `acc`.
  - `xfer` only: `cnt` ← 0.
  - `i_ack` only: `cnt` ← `cnt`+1.
- Word retire:
  - `o_ack` && !`xfer`: `o_rdy` ← 0, and `o_dat` keeps its last value.
- Protocol guarantees:
  - `o_rdy`/`o_dat` never change while `o_rdy`=1 && `o_ack`=0.
  - `i_ack` never asserts without `i_rdy`.
- Reset: `acc`=0, `cnt`=0, `o_rdy`=0, `o_dat`=0. Combinationally this gives `i_ack`=`i_rdy`.
- Reset mid-word: the partial word is discarded and the pending output word is dropped.

## Timing
- Latency: last beat of a word accepted at edge k → `o_rdy`=1 from edge k+1.
  - Requires the output register to be free (or acked) in cycle k+1.
- Throughput: one beat per cycle sustained, provided `o_ack` is asserted within `RATIO` cycles of `o_rdy`. There are no bubbles between words.
- Backpressure, with `full`=1 and the output held:
  - `i_ack`=0.
  - The upstream holds its beat.
  - `acc` and `cnt` are frozen.
- Simultaneous `o_ack` and `full` in the same cycle: the new word replaces the old in that cycle, and `o_rdy` stays high. This is the only case where `o_dat` changes while `o_rdy` is high, and it is legal because `o_ack` was asserted.
- `o_ack` while `o_rdy`=0: ignored.
- `rst` dominates all other inputs in the cycle it is sampled.

## Structure
- Shared package `pp_pkg`: `PP_CNT_W(RATIO)` width function. `pp_pkg` is shared with other rdy/ack blocks.
- Sub-module `pp_out_slice`: a generic rdy/ack holding register (load, hold, retire) used for the output stage. It is reusable by other pipeline stages.
- Total RTL budget: ~150–250 lines.

## Test plan
All scenarios run with `IN_BW`=8 and `RATIO`=4.
- Reset, then 4 beats back-to-back (`0x11 0x22 0x33 0x44`), `o_ack` tied 1, `MSB_FIRST`=1 → `o_dat`=`0x11223344`, with `o_rdy` high one cycle after the 4th `i_ack`.
- Same stimulus with `MSB_FIRST`=0 → `o_dat`=`0x44332211`.
- 12 continuous beats (`0x00`..`0x0B`) with `o_ack`=1 → three words (`0x00010203`, `0x04050607`, `0x08090A0B`), and `i_ack` high in all 12 cycles.
- `o_ack` held 0 for 20 cycles after the first word:
  - 4 more beats are accepted;
  - then `i_ack`=0 with `i_rdy`=1;
  - `o_dat` stays `0x11223344` throughout;
  - on `o_ack`, `o_dat` becomes the second word in the same cycle.
- Assert `rst` after 2 of 4 beats, then send `0xA0 0xA1 0xA2 0xA3` → only `0xA0A1A2A3` is output, and `o_rdy`=0 during reset.
- Randomized `PPRandomSrc`/`PPRandomDst` (PROB=128) plus `PPCheck` on both ports, with 1000 bytes from file → `PPFileMonitor` reports 250 words received and 0 errors, and no protocol abort.
